// File: rtl/cell_draw_queue_pkg.sv
// Shared constants, types and coordinate helpers for the cell draw queue.
// Defines the board geometry, the FSM encoding and the queued request layout.
package cell_draw_queue_pkg;

    localparam int CELL_W   = 64;
    localparam int CELL_H   = 24;
    localparam int X_W      = 4;
    localparam int Y_W      = 5;
    localparam int COLOR_W  = 9;
    localparam int PX_W     = 10;
    localparam int PY_W     = 9;
    localparam int DEF_COLS = 10;
    localparam int DEF_ROWS = 20;

    localparam logic [COLOR_W-1:0] DEF_BG_COLOR = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] color;
    } cell_req_t;

    function automatic logic [PX_W-1:0] cell_x0(input logic [X_W-1:0] x);
        return PX_W'(x) * PX_W'(CELL_W);
    endfunction

    // 19 * 24 = 456 is the largest origin, so 9 bits never overflow
    function automatic logic [PY_W-1:0] cell_y0(input logic [Y_W-1:0] y);
        return PY_W'(y) * PY_W'(CELL_H);
    endfunction

endpackage

// File: rtl/cell_draw_queue_draw_fifo.sv
// Synchronous request FIFO with flush and a write port into the newest entry.
// A flush and a push in the same cycle leave exactly the pushed entry queued.
module cell_draw_queue_draw_fifo
    import cell_draw_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  cell_req_t              push_data_i,
    input  logic                   pop_i,
    input  logic                   tail_we_i,
    input  logic [COLOR_W-1:0]     tail_color_i,
    output cell_req_t              head_o,
    output logic [X_W+Y_W-1:0]     tail_xy_o,
    output logic [CW-1:0]          count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    cell_req_t       mem_q [DEPTH];
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   tail_idx;
    cell_req_t       tail_ent;

    assign tail_idx  = wptr_q - AW'(1);
    assign wr_idx    = flush_i ? '0 : wptr_q;
    assign head_o    = mem_q[rptr_q];
    assign tail_ent  = mem_q[tail_idx];
    assign tail_xy_o = {tail_ent.x, tail_ent.y};
    assign count_o   = count_q;
    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (flush_i) begin
            rptr_d  = '0;
            wptr_d  = push_i ? AW'(1) : '0;
            count_d = push_i ? CW'(1) : '0;
        end else begin
            if (push_i) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (pop_i) begin
                rptr_d = rptr_q + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_idx] <= push_data_i;
        end else if (tail_we_i && !flush_i) begin
            mem_q[tail_idx].color <= tail_color_i;
        end
    end

endmodule

// File: rtl/cell_draw_queue.sv
// Queues cell draw requests and sequences the box painter, including board clear sweeps.
// Define DRAW_QUEUE_COALESCE_EN to merge a request into the newest queued entry of the same cell.
module cell_draw_queue
    import cell_draw_queue_pkg::*;
#(
    parameter int                 DEPTH    = 8,
    parameter int                 COLS     = DEF_COLS,
    parameter int                 ROWS     = DEF_ROWS,
    parameter logic [COLOR_W-1:0] BG_COLOR = DEF_BG_COLOR
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic               req_valid,
    input  logic [X_W-1:0]     req_x,
    input  logic [Y_W-1:0]     req_y,
    input  logic [COLOR_W-1:0] req_color,
    output logic               req_ready,
    input  logic               clear_req,
    output logic               paint_start,
    output logic [PX_W-1:0]    paint_x0,
    output logic [PY_W-1:0]    paint_y0,
    output logic [COLOR_W-1:0] paint_color,
    input  logic               paint_busy,
    input  logic               paint_done,
    output logic               clearing,
    output logic               err_oob
);

`ifdef DRAW_QUEUE_COALESCE_EN
    localparam bit COALESCE = 1'b1;
`else
    localparam bit COALESCE = 1'b0;
`endif

    localparam int             CW     = $clog2(DEPTH + 1);
    localparam logic [X_W:0]   X_LIM  = (X_W+1)'(COLS);
    localparam logic [Y_W:0]   Y_LIM  = (Y_W+1)'(ROWS);
    localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);

    state_e             state_q, state_d;
    logic [PX_W-1:0]    x0_q, x0_d;
    logic [PY_W-1:0]    y0_q, y0_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic [X_W-1:0]     cx_q, cx_d;
    logic [Y_W-1:0]     cy_q, cy_d;
    logic               clearing_q, clearing_d;
    logic               sweep_q, sweep_d;
    logic               err_q, err_d;

    cell_req_t          head;
    cell_req_t          push_data;
    logic [X_W+Y_W-1:0] tail_xy;
    logic [CW-1:0]      fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               tail_we;
    logic               in_range;
    logic               coal_hit;

    assign in_range = ({1'b0, req_x} < X_LIM) && ({1'b0, req_y} < Y_LIM);

    // An entry being popped this cycle is already owned by the painter
    assign coal_hit = COALESCE && !fifo_empty && !clear_req
                      && (tail_xy == {req_x, req_y})
                      && !(pop && fifo_count == CW'(1));

    assign req_ready = !fifo_full || coal_hit;
    assign push      = req_valid && in_range && !fifo_full && !coal_hit;
    assign tail_we   = req_valid && in_range && coal_hit;
    assign err_d     = req_valid && !in_range;

    assign push_data = '{x: req_x, y: req_y, color: req_color};

    cell_draw_queue_draw_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (CLOCK_50),
        .rst_ni       (resetn),
        .flush_i      (clear_req),
        .push_i       (push),
        .push_data_i  (push_data),
        .pop_i        (pop),
        .tail_we_i    (tail_we),
        .tail_color_i (req_color),
        .head_o       (head),
        .tail_xy_o    (tail_xy),
        .count_o      (fifo_count),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        color_d    = color_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        clearing_d = clearing_q;
        sweep_d    = sweep_q;
        pop        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!paint_busy && !clear_req) begin
                    if (clearing_q) begin
                        state_d = ST_ISSUE;
                        x0_d    = cell_x0(cx_q);
                        y0_d    = cell_y0(cy_q);
                        color_d = BG_COLOR;
                        sweep_d = 1'b1;
                    end else if (!fifo_empty) begin
                        state_d = ST_ISSUE;
                        x0_d    = cell_x0(head.x);
                        y0_d    = cell_y0(head.y);
                        color_d = head.color;
                        sweep_d = 1'b0;
                        pop     = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (paint_done) begin
                    state_d = ST_IDLE;
                    if (sweep_q) begin
                        sweep_d = 1'b0;
                        if (cx_q == X_LAST) begin
                            cx_d = '0;
                            if (cy_q == Y_LAST) begin
                                cy_d       = '0;
                                clearing_d = 1'b0;
                            end else begin
                                cy_d = cy_q + Y_W'(1);
                            end
                        end else begin
                            cx_d = cx_q + X_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new clear wins over any sweep progress, including a done this cycle
        if (clear_req) begin
            clearing_d = 1'b1;
            cx_d       = '0;
            cy_d       = '0;
            sweep_d    = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            x0_q       <= '0;
            y0_q       <= '0;
            color_q    <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            clearing_q <= 1'b0;
            sweep_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            color_q    <= color_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            clearing_q <= clearing_d;
            sweep_q    <= sweep_d;
            err_q      <= err_d;
        end
    end

    assign paint_start = (state_q == ST_ISSUE);
    assign paint_x0    = x0_q;
    assign paint_y0    = y0_q;
    assign paint_color = color_q;
    assign clearing    = clearing_q;
    assign err_oob     = err_q;

endmodule
